wb_ram_slave: RTL and testbench

//  Wishbone B3 slave (responder) for on-chip RAM, attached to one sN_* port of wb_arb.

---
 rtl/wb_ram_slave.sv | 167 ++++++++++++++++
 tb/tb_wb_ram_slave.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ram_slave.sv
// Wishbone B3 on-chip RAM slave: classic cycles with WAIT_CYCLES wait states plus registered-feedback incrementing bursts.
// Define WB_RAM_ERR_EN to add err_o and reject requests whose address bits above the RAM window are non-zero.

module wb_ram_slave #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic [29:0] addr_i,
    input  logic [2:0]  cti_i,
    input  logic [1:0]  bte_i,
    input  logic [3:0]  sel_i,
    input  logic        we_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o
`ifdef WB_RAM_ERR_EN
    ,
    output logic        err_o
`endif
);

    localparam logic [3:0] WAIT_INIT   = 4'(WAIT_CYCLES);
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_BURST
    } state_t;

    state_t               state;
    logic [31:0]          mem [0:(1<<ADDR_BITS)-1];
    logic [ADDR_BITS-1:0] cur_addr;
    logic [ADDR_BITS-1:0] next_addr;
    logic [2:0]           cti_q;
    logic [1:0]           bte_q;
    logic                 we_q;
    logic                 err_q;
    logic [3:0]           wait_cnt;
    logic                 req_err;
    logic                 beat_taken;
    logic                 burst_last;
    logic                 mem_we;

`ifdef WB_RAM_ERR_EN
    assign req_err = |addr_i[29:ADDR_BITS];
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_i[29:ADDR_BITS];
    assign req_err        = 1'b0;
`endif

    // A beat completes only when the master still strobes during a cycle we acknowledge.
    assign beat_taken = ack_o & cyc_i & stb_i;
    assign burst_last = (cti_i == CTI_END) || (cti_i == CTI_CLASSIC);
    assign mem_we     = beat_taken & we_q;

    always_comb begin
        next_addr = cur_addr + ADDR_BITS'(1);
        case (bte_q)
            BTE_WRAP4:  next_addr = {cur_addr[ADDR_BITS-1:2], cur_addr[1:0] + 2'd1};
            BTE_WRAP8:  next_addr = {cur_addr[ADDR_BITS-1:3], cur_addr[2:0] + 3'd1};
            BTE_WRAP16: next_addr = {cur_addr[ADDR_BITS-1:4], cur_addr[3:0] + 4'd1};
            default:    next_addr = cur_addr + ADDR_BITS'(1);
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_i[b]) begin
                    mem[cur_addr][8*b +: 8] <= data_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            state    <= ST_IDLE;
            ack_o    <= 1'b0;
            data_o   <= 32'h0;
            cur_addr <= '0;
            cti_q    <= CTI_CLASSIC;
            bte_q    <= 2'b00;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            wait_cnt <= 4'd0;
`ifdef WB_RAM_ERR_EN
            err_o    <= 1'b0;
`endif
        end else begin
            ack_o <= 1'b0;
`ifdef WB_RAM_ERR_EN
            err_o <= 1'b0;
`endif
            if (!cyc_i) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (stb_i) begin
                            cur_addr <= addr_i[ADDR_BITS-1:0];
                            cti_q    <= cti_i;
                            bte_q    <= bte_i;
                            we_q     <= we_i;
                            err_q    <= req_err;
                            wait_cnt <= WAIT_INIT;
                            state    <= ST_WAIT;
                        end
                    end
                    // The last wait cycle also fetches the first read word so it is ready with ack.
                    ST_WAIT: begin
                        if (wait_cnt != 4'd0) begin
                            wait_cnt <= wait_cnt - 4'd1;
                        end else begin
                            data_o <= mem[cur_addr];
                            if (err_q) begin
`ifdef WB_RAM_ERR_EN
                                err_o <= 1'b1;
`endif
                                state <= ST_ACK;
                            end else if (cti_q == CTI_INCR) begin
                                ack_o <= 1'b1;
                                state <= ST_BURST;
                            end else begin
                                ack_o <= 1'b1;
                                state <= ST_ACK;
                            end
                        end
                    end
                    ST_ACK: begin
                        state <= ST_IDLE;
                    end
                    // Pre-read the next burst word on each taken beat so beats stream back to back.
                    ST_BURST: begin
                        if (beat_taken) begin
                            if (burst_last) begin
                                state <= ST_IDLE;
                            end else begin
                                cur_addr <= next_addr;
                                data_o   <= mem[next_addr];
                                ack_o    <= 1'b1;
                            end
                        end else begin
                            ack_o <= stb_i;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wb_ram_slave.sv
// Randomized scoreboard bench for wb_ram_slave: the driver queues expected beats from a word-array model,
// an independent monitor pops and checks one entry per acknowledged strobed beat.

module tb_wb_ram_slave;

    localparam int AB    = 10;
    localparam int WC    = 1;
    localparam int DEPTH = 1 << AB;
    // Inputs change 1 time unit after an edge; the first negedge comes before the request edge,
    // and ack rises on the (WC+1)th edge after it.
    localparam int EXP_LAT = WC + 3;

    logic        wb_clk = 1'b0;
    logic        wb_rst;
    logic        cyc_i;
    logic        stb_i;
    logic [29:0] addr_i;
    logic [2:0]  cti_i;
    logic [1:0]  bte_i;
    logic [3:0]  sel_i;
    logic        we_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ack_o;
`ifdef WB_RAM_ERR_EN
    logic        err_o;
`endif

    typedef struct {
        bit          chk;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_mem [DEPTH];
    int          total = 0;
    int          bad   = 0;

    always #5 wb_clk = ~wb_clk;

    wb_ram_slave #(.ADDR_BITS(AB), .WAIT_CYCLES(WC)) dut (
        .wb_clk (wb_clk),
        .wb_rst (wb_rst),
        .cyc_i  (cyc_i),
        .stb_i  (stb_i),
        .addr_i (addr_i),
        .cti_i  (cti_i),
        .bte_i  (bte_i),
        .sel_i  (sel_i),
        .we_i   (we_i),
        .data_i (data_i),
        .data_o (data_o),
        .ack_o  (ack_o)
`ifdef WB_RAM_ERR_EN
        ,
        .err_o  (err_o)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic idleBus();
        cyc_i  = 1'b0;
        stb_i  = 1'b0;
        we_i   = 1'b0;
        addr_i = '0;
        cti_i  = 3'b000;
        bte_i  = 2'b00;
        sel_i  = 4'h0;
        data_i = 32'h0;
    endtask

    function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] wdata, input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = wdata[8*b +: 8];
        end
        return r;
    endfunction

    // Monitor: every strobed, acknowledged beat consumes one scoreboard entry.
    initial begin
        forever begin
            exp_t e;
            @(negedge wb_clk);
            if (wb_rst && cyc_i && stb_i && ack_o) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected ack: got ack with empty scoreboard, expected none");
                end else begin
                    e = sb_q.pop_front();
                    if (e.chk) checkOutput("read data", data_o, e.data);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [29:0] waddr, input bit we, input logic [31:0] wdata,
                                 input logic [3:0] sel, output int lat, output logic [31:0] rdata);
        exp_t e;
        int   idx;
        idx    = int'(waddr[AB-1:0]);
        e.chk  = !we;
        e.data = model_mem[idx];
        if (we) model_mem[idx] = mergeBytes(model_mem[idx], wdata, sel);
        sb_q.push_back(e);
        @(posedge wb_clk); #1;
        cyc_i  = 1'b1;
        stb_i  = 1'b1;
        we_i   = we;
        addr_i = waddr;
        cti_i  = 3'b000;
        bte_i  = 2'b00;
        sel_i  = sel;
        data_i = wdata;
        lat    = 0;
        do begin
            @(negedge wb_clk);
            lat++;
        end while (!ack_o && lat < 64);
        rdata = data_o;
        if (!ack_o) begin
            total++;
            bad++;
            $display("[TB] FAIL classic ack timeout: got no ack in %0d cycles, expected one", lat);
        end
        @(posedge wb_clk); #1;
        stb_i = 1'b0;
        @(negedge wb_clk);
        checkOutput("classic ack one cycle", 32'(ack_o), 32'h0);
        idleBus();
    endtask

    task automatic burstXfer(input int unsigned start, input logic [1:0] bte, input bit we, input int n,
                             input int stall_at, input int stall_len, input bit rand_sel,
                             output int acc_cnt, output int gap);
        int unsigned seq[$];
        logic [31:0] wd[$];
        logic [3:0]  sl[$];
        int unsigned blk, a;
        int          k, stall_rem, cycles, budget;
        bit          started, acc;
        exp_t        e;
        blk = (bte == 2'b00) ? 0 : (2 << bte);
        for (int i = 0; i < n; i++) begin
            if (blk == 0) a = (start + i) % DEPTH;
            else          a = (start - start % blk) + ((start % blk) + i) % blk;
            seq.push_back(a);
            wd.push_back($urandom);
            sl.push_back(rand_sel ? 4'($urandom_range(1, 15)) : 4'hF);
            e.chk  = !we;
            e.data = model_mem[a];
            if (we) model_mem[a] = mergeBytes(model_mem[a], wd[i], sl[i]);
            sb_q.push_back(e);
        end
        k = 0; stall_rem = 0; cycles = 0; started = 0; acc_cnt = 0; gap = 0;
        budget = 64 + n * 8;
        @(posedge wb_clk); #1;
        cyc_i  = 1'b1;
        stb_i  = 1'b1;
        we_i   = we;
        bte_i  = bte;
        cti_i  = (n == 1) ? 3'b111 : 3'b010;
        addr_i = 30'(seq[0]);
        data_i = wd[0];
        sel_i  = sl[0];
        while (k < n && cycles < budget) begin
            @(negedge wb_clk);
            cycles++;
            acc = ack_o && stb_i;
            if (ack_o) started = 1;
            else if (started) gap++;
            @(posedge wb_clk); #1;
            if (acc) begin
                acc_cnt++;
                k++;
                if (k == stall_at) stall_rem = stall_len;
            end
            if (k < n) begin
                if (stall_rem > 0) begin
                    stb_i = 1'b0;
                    stall_rem--;
                end else begin
                    stb_i  = 1'b1;
                    cti_i  = (k == n - 1) ? 3'b111 : 3'b010;
                    addr_i = 30'(seq[k]);
                    data_i = wd[k];
                    sel_i  = sl[k];
                end
            end
        end
        if (k < n) begin
            total++;
            bad++;
            $display("[TB] FAIL burst timeout: got %0d beats, expected %0d", k, n);
        end
        idleBus();
        @(negedge wb_clk);
        checkOutput("ack low after burst", 32'(ack_o), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish within 100000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          lat, acc, gap, cnt;
        logic [31:0] rd, old;
        exp_t        e;

        idleBus();
        wb_rst = 1'b0;
        repeat (3) @(negedge wb_clk);
        checkOutput("reset ack_o", 32'(ack_o), 32'h0);
        checkOutput("reset data_o", data_o, 32'h0);
        @(posedge wb_clk); #2;
        wb_rst = 1'b1;

        burstXfer(0, 2'b00, 1'b1, DEPTH, 0, 0, 1'b0, acc, gap);
        checkOutput("init fill beats", 32'(acc), 32'(DEPTH));

        applyStimulus(30'(32'h10 >> 2), 1'b1, 32'hDEADBEEF, 4'hF, lat, rd);
        checkOutput("classic write latency", 32'(lat), 32'(EXP_LAT));
        applyStimulus(30'(32'h10 >> 2), 1'b0, 32'h0, 4'hF, lat, rd);
        checkOutput("classic read value", rd, 32'hDEADBEEF);
        applyStimulus(30'(32'h10 >> 2), 1'b1, 32'h0000_5500, 4'b0010, lat, rd);
        applyStimulus(30'(32'h10 >> 2), 1'b0, 32'h0, 4'hF, lat, rd);
        checkOutput("byte lane merge", rd, 32'hDEAD55EF);

        burstXfer(6, 2'b01, 1'b0, 4, 0, 0, 1'b0, acc, gap);
        checkOutput("wrap4 beats", 32'(acc), 32'd4);
        checkOutput("wrap4 ack gap", 32'(gap), 32'd0);

        burstXfer(0, 2'b00, 1'b1, 8, 4, 2, 1'b0, acc, gap);
        checkOutput("stalled burst beats", 32'(acc), 32'd8);
        checkOutput("stalled burst ack gap", 32'(gap), 32'd2);
        burstXfer(0, 2'b00, 1'b0, 8, 0, 0, 1'b0, acc, gap);
        checkOutput("readback beats", 32'(acc), 32'd8);

        burstXfer(DEPTH - 2, 2'b00, 1'b0, 4, 0, 0, 1'b0, acc, gap);
        checkOutput("linear rollover beats", 32'(acc), 32'd4);

        // Abandon a write while it is still waiting: nothing may be acked or stored.
        old = model_mem[9];
        @(posedge wb_clk); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; addr_i = 30'd9; data_i = ~old; sel_i = 4'hF;
        @(posedge wb_clk); #1;
        idleBus();
        cnt = 0;
        repeat (6) begin
            @(negedge wb_clk);
            if (ack_o) cnt++;
        end
        checkOutput("no ack after cyc drop", 32'(cnt), 32'h0);
        applyStimulus(30'd9, 1'b0, 32'h0, 4'hF, lat, rd);
        checkOutput("word kept after cyc drop", rd, old);

        // Asynchronous reset while a read is being acknowledged.
        e.chk  = 1'b1;
        e.data = model_mem[4];
        sb_q.push_back(e);
        @(posedge wb_clk); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; addr_i = 30'd4; sel_i = 4'hF;
        cnt = 0;
        do begin
            @(negedge wb_clk);
            cnt++;
        end while (!ack_o && cnt < 64);
        checkOutput("ack before async reset", 32'(ack_o), 32'h1);
        #2 wb_rst = 1'b0;
        #1;
        checkOutput("async reset ack_o", 32'(ack_o), 32'h0);
        checkOutput("async reset data_o", data_o, 32'h0);
        idleBus();
        sb_q.delete();
        @(posedge wb_clk); #2;
        wb_rst = 1'b1;
        applyStimulus(30'd4, 1'b0, 32'h0, 4'hF, lat, rd);
        checkOutput("latency after reset", 32'(lat), 32'(EXP_LAT));

`ifdef WB_RAM_ERR_EN
        @(posedge wb_clk); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; addr_i = 30'h0400_0000; sel_i = 4'hF;
        cnt = 0;
        do begin
            @(negedge wb_clk);
            cnt++;
        end while (!err_o && !ack_o && cnt < 64);
        checkOutput("err_o out of range", 32'(err_o), 32'h1);
        checkOutput("ack_o on error", 32'(ack_o), 32'h0);
        checkOutput("error latency", 32'(cnt), 32'(EXP_LAT));
        @(posedge wb_clk); #1;
        stb_i = 1'b0;
        @(negedge wb_clk);
        checkOutput("err_o one cycle", 32'(err_o), 32'h0);
        idleBus();
`endif

        for (int it = 0; it < 60; it++) begin
            int unsigned op, a, stall_at, stall_len, n;
            logic [29:0] fa;
            op = $urandom_range(0, 3);
            if (op < 2) begin
                a  = $urandom_range(0, DEPTH - 1);
                fa = 30'(a);
`ifndef WB_RAM_ERR_EN
                fa = fa | (30'($urandom) << AB);
`endif
                applyStimulus(fa, op == 1, $urandom, 4'($urandom_range(0, 15)), lat, rd);
                checkOutput("random classic latency", 32'(lat), 32'(EXP_LAT));
            end else begin
                n         = $urandom_range(1, 12);
                stall_at  = (n > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, n - 1) : 0;
                stall_len = (stall_at != 0) ? $urandom_range(1, 3) : 0;
                burstXfer($urandom_range(0, DEPTH - 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                          int'(n), int'(stall_at), int'(stall_len), 1'b1, acc, gap);
                checkOutput("random burst beats", 32'(acc), n);
                checkOutput("random burst ack gap", 32'(gap), stall_len);
            end
        end

        repeat (2) @(negedge wb_clk);
        checkOutput("scoreboard drained", 32'(sb_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
